// File: rtl/quant_pkg.sv
// Shared quantization constants and output-range helpers for the
// quantize/dequantize stages around the integer matmul array.
package quant_pkg;

  // Default number of fraction bits for Q16.16 activations and scales
  localparam int FRAC_BITS_DEF = 16;

  // X tensor: scale 0.03675, stored as Q16.16 scale and reciprocal
  localparam logic [31:0] SCALE_X     = 32'd2408;
  localparam logic [31:0] INV_SCALE_X = 32'd1783293;

  // Y tensor: scale 0.0625, stored as Q16.16 scale and reciprocal
  localparam logic [31:0] SCALE_Y     = 32'd4096;
  localparam logic [31:0] INV_SCALE_Y = 32'd1048576;

  // Most negative value of a signed two's complement integer of width w
  function automatic longint qmin(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  // Most positive value of a signed two's complement integer of width w
  function automatic longint qmax(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

endpackage

// File: rtl/quant_round_sat.sv
// Combinational round-half-away-from-zero and saturation math.
// The two paths are independent so the caller can put a register
// between rounding and clipping.
module quant_round_sat
  import quant_pkg::*;
#(
  parameter int WIDTH_PROD   = 64,
  parameter int WIDTH_OUTPUT = 8,
  parameter int SHIFT        = 32
) (
  input  logic signed [WIDTH_PROD-1:0]   prod_s,
  output logic signed [WIDTH_PROD-1:0]   rnd_s,
  input  logic signed [WIDTH_PROD-1:0]   rnd_r,
  output logic signed [WIDTH_OUTPUT-1:0] q_s,
  output logic                           sat_s
);

  localparam logic signed [WIDTH_PROD-1:0] HALF =
    {{(WIDTH_PROD-1){1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [WIDTH_PROD-1:0] QMIN_W = WIDTH_PROD'(qmin(WIDTH_OUTPUT));
  localparam logic signed [WIDTH_PROD-1:0] QMAX_W = WIDTH_PROD'(qmax(WIDTH_OUTPUT));

  logic signed [WIDTH_PROD-1:0] mag_s;
  logic signed [WIDTH_PROD-1:0] shifted_s;

  // Round on the magnitude so ties move away from zero for both signs
  always_comb begin
    mag_s     = prod_s;
    shifted_s = '0;
    rnd_s     = '0;
    if (prod_s < 0) begin
      mag_s = -prod_s;
    end else begin
      mag_s = prod_s;
    end
    shifted_s = (mag_s + HALF) >>> SHIFT;
    if (prod_s < 0) begin
      rnd_s = -shifted_s;
    end else begin
      rnd_s = shifted_s;
    end
  end

  // Clip the full-width rounded value; never truncate before comparing
  always_comb begin
    q_s   = '0;
    sat_s = 1'b0;
    if (rnd_r > QMAX_W) begin
      q_s   = QMAX_W[WIDTH_OUTPUT-1:0];
      sat_s = 1'b1;
    end else if (rnd_r < QMIN_W) begin
      q_s   = QMIN_W[WIDTH_OUTPUT-1:0];
      sat_s = 1'b1;
    end else begin
      q_s   = rnd_r[WIDTH_OUTPUT-1:0];
      sat_s = 1'b0;
    end
  end

endmodule

// File: rtl/quantize_q16.sv
// Q16.16 -> signed integer quantizer: multiply by reciprocal scale,
// round half away from zero, saturate. Fixed 3-cycle latency, one
// sample per cycle, with a batch counter flagging the last result.
module quantize_q16
  import quant_pkg::*;
#(
  parameter int          WIDTH_INPUT     = 32,
  parameter int          WIDTH_OUTPUT    = 8,
  parameter int          FRAC_BITS       = FRAC_BITS_DEF,
  parameter logic [31:0] INV_SCALE       = INV_SCALE_X,
  parameter int          NUM_COUNTER_BIT = 3,
  parameter int          NUM_CALCULATE   = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic signed [WIDTH_INPUT-1:0]  din_i,
  input  logic                           valid_i,
  output logic                           valid_o,
  output logic                           done_o,
  output logic                           sat_o,
  output logic signed [WIDTH_OUTPUT-1:0] dout_o
);

  localparam int WIDTH_PROD = 2 * WIDTH_INPUT;
  localparam int SHIFT      = 2 * FRAC_BITS;
  localparam logic [WIDTH_INPUT-1:0] INV_SCALE_U = WIDTH_INPUT'(INV_SCALE);
  localparam logic [NUM_COUNTER_BIT-1:0] CNT_LAST = NUM_COUNTER_BIT'(NUM_CALCULATE - 1);

  logic signed [WIDTH_PROD-1:0]   din_ext_s;
  logic signed [WIDTH_PROD-1:0]   scale_ext_s;
  logic signed [WIDTH_PROD-1:0]   prod_s;
  logic signed [WIDTH_PROD-1:0]   prod_r;
  logic signed [WIDTH_PROD-1:0]   rnd_s;
  logic signed [WIDTH_PROD-1:0]   rnd_r;
  logic signed [WIDTH_OUTPUT-1:0] q_s;
  logic                           sat_s;
  logic                           v1_r;
  logic                           v2_r;
  logic [NUM_COUNTER_BIT-1:0]     cnt_r;

  // The reciprocal scale is always a positive operand, so zero-extend it
  assign din_ext_s   = WIDTH_PROD'(din_i);
  assign scale_ext_s = $signed({{WIDTH_INPUT{1'b0}}, INV_SCALE_U});
  assign prod_s      = din_ext_s * scale_ext_s;

  quant_round_sat #(
    .WIDTH_PROD   (WIDTH_PROD),
    .WIDTH_OUTPUT (WIDTH_OUTPUT),
    .SHIFT        (SHIFT)
  ) u_round_sat (
    .prod_s (prod_r),
    .rnd_s  (rnd_s),
    .rnd_r  (rnd_r),
    .q_s    (q_s),
    .sat_s  (sat_s)
  );

  // Three pipeline stages; data loads every cycle, valid travels alongside
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prod_r  <= '0;
      v1_r    <= 1'b0;
      rnd_r   <= '0;
      v2_r    <= 1'b0;
      dout_o  <= '0;
      sat_o   <= 1'b0;
      valid_o <= 1'b0;
    end else begin
      prod_r  <= prod_s;
      v1_r    <= valid_i;
      rnd_r   <= rnd_s;
      v2_r    <= v1_r;
      dout_o  <= q_s;
      sat_o   <= sat_s;
      valid_o <= v2_r;
    end
  end

  // Batch counter advances with the result entering the output register,
  // so done_o is registered and lines up with the last valid_o of a batch
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_r  <= '0;
      done_o <= 1'b0;
    end else if (v2_r) begin
      done_o <= (cnt_r == CNT_LAST);
      if (cnt_r == CNT_LAST) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + {{(NUM_COUNTER_BIT-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_r  <= cnt_r;
      done_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_quantize_q16.sv
// Self-checking bench for quantize_q16: two instances (reciprocal scale
// 1783293 and 1.0) run the same directed stimulus and are compared every
// cycle against an arithmetic model of quantization and batching.
module tb_quantize_q16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [31:0] din = 32'd0;

  logic       va, da, sa;
  logic [7:0] qa;
  logic       vb, db, sb;
  logic [7:0] qb;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  quantize_q16 #(.INV_SCALE(32'd1783293)) dut_a (
    .clk_i(clk), .rst_i(rst), .din_i(din), .valid_i(valid),
    .valid_o(va), .done_o(da), .sat_o(sa), .dout_o(qa)
  );

  quantize_q16 #(.INV_SCALE(32'd65536)) dut_b (
    .clk_i(clk), .rst_i(rst), .din_i(din), .valid_i(valid),
    .valid_o(vb), .done_o(db), .sat_o(sb), .dout_o(qb)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Real-number meaning: value = din/2^16 * inv/2^16, round half away, clip to int8
  function automatic int model_q(input logic [31:0] d, input longint inv, output bit sat);
    longint p, mag, q;
    p   = longint'($signed(d)) * inv;
    mag = (p < 64'sd0) ? -p : p;
    q   = mag / 64'sd4294967296;
    if ((mag % 64'sd4294967296) >= 64'sd2147483648) q = q + 64'sd1;
    if (p < 64'sd0) q = -q;
    sat = 1'b0;
    if (q > 64'sd127) begin
      q = 64'sd127;
      sat = 1'b1;
    end else if (q < -64'sd128) begin
      q = -64'sd128;
      sat = 1'b1;
    end
    return int'(q);
  endfunction

  // Model state: expected results indexed by the edge they are due at
  longint inv_k [2] = '{64'sd1783293, 64'sd65536};
  bit     mv [2][4];
  int     mq [2][4];
  bit     ms [2][4];
  int     bcnt [2];
  int     ec = 0;

  task automatic cmp(input string p, input bit r, input bit ev, input int eq, input bit es,
                     input bit ed, input logic vo, input logic [7:0] qo, input logic so,
                     input logic dn);
    if (r) begin
      chk({p, "_rst_valid"}, int'(vo), 0);
      chk({p, "_rst_dout"}, int'($signed(qo)), 0);
      chk({p, "_rst_sat"}, int'(so), 0);
      chk({p, "_rst_done"}, int'(dn), 0);
    end else begin
      chk({p, "_valid"}, int'(vo), int'(ev));
      if (ev) begin
        chk({p, "_dout"}, int'($signed(qo)), eq);
        chk({p, "_sat"}, int'(so), int'(es));
        chk({p, "_done"}, int'(dn), int'(ed));
      end else begin
        chk({p, "_done_idle"}, int'(dn), 0);
      end
    end
  endtask

  // Model update on each edge, then compare both DUTs just after it
  initial begin
    bit          r_s, v_s, s_tmp;
    logic [31:0] d_s;
    bit          ev [2];
    int          eq [2];
    bit          es [2];
    bit          ed [2];
    int          slot, nslot;
    forever begin
      @(posedge clk);
      r_s = rst; v_s = valid; d_s = din;
      slot = ec % 4; nslot = (ec + 2) % 4;
      for (int k = 0; k < 2; k++) begin
        ev[k] = 1'b0; eq[k] = 0; es[k] = 1'b0; ed[k] = 1'b0;
        if (r_s) begin
          for (int j = 0; j < 4; j++) mv[k][j] = 1'b0;
          bcnt[k] = 0;
        end else begin
          ev[k] = mv[k][slot]; eq[k] = mq[k][slot]; es[k] = ms[k][slot];
          mv[k][slot] = 1'b0;
          if (v_s) begin
            mq[k][nslot] = model_q(d_s, inv_k[k], s_tmp);
            ms[k][nslot] = s_tmp;
            mv[k][nslot] = 1'b1;
          end
          if (ev[k]) begin
            ed[k]   = (bcnt[k] == 3);
            bcnt[k] = (bcnt[k] + 1) % 4;
          end
        end
      end
      ec++;
      #1;
      cmp("A", r_s, ev[0], eq[0], es[0], ed[0], va, qa, sa, da);
      cmp("B", r_s, ev[1], eq[1], es[1], ed[1], vb, qb, sb, db);
    end
  end

  task automatic drive(input bit r, input bit v, input logic [31:0] d);
    @(negedge clk);
    rst = r; valid = v; din = d;
  endtask

  logic [31:0] vec [10] = '{32'h00010000, 32'h00028000, 32'hFFFD8000, 32'h00018000,
                            32'h00050000, 32'hFFFB0000, 32'h80000000, 32'hFFFF8000,
                            32'h7FFFFFFF, 32'h00007FFF};

  // Pin the model with hand-computed values, then run directed stimulus
  initial begin
    int  r;
    bit  s;
    r = model_q(32'h00010000, 64'sd1783293, s); chk("model_1p0_q", r, 27); chk("model_1p0_s", int'(s), 0);
    r = model_q(32'h00028000, 64'sd65536, s);   chk("model_2p5", r, 3);
    r = model_q(32'hFFFD8000, 64'sd65536, s);   chk("model_m2p5", r, -3);
    r = model_q(32'h00018000, 64'sd65536, s);   chk("model_1p5", r, 2);
    r = model_q(32'hFFFF8000, 64'sd65536, s);   chk("model_m0p5", r, -1);
    r = model_q(32'h00050000, 64'sd1783293, s); chk("model_5p0_q", r, 127); chk("model_5p0_s", int'(s), 1);
    r = model_q(32'hFFFB0000, 64'sd1783293, s); chk("model_m5p0_q", r, -128); chk("model_m5p0_s", int'(s), 1);
    r = model_q(32'h80000000, 64'sd1783293, s); chk("model_min_q", r, -128); chk("model_min_s", int'(s), 1);

    drive(1'b1, 1'b0, 32'd0);
    drive(1'b1, 1'b0, 32'd0);
    foreach (vec[i]) drive(1'b0, 1'b1, vec[i]);
    repeat (4) drive(1'b0, 1'b0, 32'd0);

    // Fresh batch back-to-back, then a batch with one-cycle gaps
    drive(1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, vec[i]);
    repeat (4) drive(1'b0, 1'b0, 32'd0);
    for (int i = 4; i < 8; i++) begin
      drive(1'b0, 1'b1, vec[i]);
      drive(1'b0, 1'b0, 32'd0);
    end
    repeat (4) drive(1'b0, 1'b0, 32'd0);

    // Reset with two results out and two in flight, then a full batch
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, vec[i + 4]);
    drive(1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, vec[i]);
    repeat (4) drive(1'b0, 1'b0, 32'd0);

    // Reset dominates a simultaneous valid_i
    drive(1'b1, 1'b1, vec[0]);
    repeat (5) drive(1'b0, 1'b0, 32'd0);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
